// File: rtl/cache_ctrl_sa.sv
// rtl/cache_ctrl_sa.sv - N-way set-associative write-back/write-allocate data cache with miss FSM
module cache_ctrl_sa #(
    parameter int NUM_SETS   = 4,
    parameter int NUM_WAYS   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  req_ready,
    output logic [XLEN-1:0]       rdata,
    input  logic                  arbiter_grant,
    output logic                  mem_req,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [LINE_WIDTH-1:0] mem_req_data,
    input  logic                  mem_resp,
    input  logic [LINE_WIDTH-1:0] mem_resp_data,
    input  logic [ADDR_WIDTH-1:0] mem_resp_addr
);
    localparam int OFF_W = $clog2(LINE_WIDTH / 8);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WB, FETCH} state_e;

    state_e state, state_next;

    logic [TAG_W-1:0]      tag_arr   [NUM_SETS][NUM_WAYS];
    logic [LINE_WIDTH-1:0] data_arr  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]   valid_arr [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty_arr [NUM_SETS];
    logic [WAY_W-1:0]      rr_ptr    [NUM_SETS];

    logic [IDX_W-1:0]      lat_idx;
    logic [TAG_W-1:0]      lat_tag;
    logic [WAY_W-1:0]      lat_way;

    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [OFF_W-1:0]      req_off;
    logic                  hit;
    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      victim;
    logic [LINE_WIDTH-1:0] hit_line;
    logic [31:0]           sel_word;
    logic [XLEN-1:0]       load_val;
    logic [LINE_WIDTH-1:0] wmask;
    logic [LINE_WIDTH-1:0] wdata_line;
    logic [LINE_WIDTH-1:0] merged_line;
    logic                  wb_done;
    logic                  fill_ok;
    logic                  unused_resp_off;

    assign req_idx = req_addr[OFF_W +: IDX_W];
    assign req_tag = req_addr[ADDR_WIDTH-1 -: TAG_W];

    // Sizes: 0=byte, 1=half, 2=word; sub-size address bits are forced to zero.
    always_comb begin
        req_off = req_addr[OFF_W-1:0];
        case (req_size)
            2'd0:    req_off = req_addr[OFF_W-1:0];
            2'd1:    req_off[0] = 1'b0;
            default: req_off[1:0] = 2'b00;
        endcase
    end

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_arr[req_idx][w] && tag_arr[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest invalid way wins; otherwise fall back to the set's round-robin pointer.
    always_comb begin
        victim = rr_ptr[req_idx];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_arr[req_idx][w]) begin
                victim = WAY_W'(w);
            end
        end
    end

    assign hit_line = data_arr[req_idx][hit_way];
    assign sel_word = 32'(hit_line >> {req_off, 3'b000});

    always_comb begin
        case (req_size)
            2'd0: begin
                load_val = XLEN'(sel_word[7:0]);
                if (!req_unsigned && sel_word[7]) load_val = load_val | ~XLEN'(8'hFF);
            end
            2'd1: begin
                load_val = XLEN'(sel_word[15:0]);
                if (!req_unsigned && sel_word[15]) load_val = load_val | ~XLEN'(16'hFFFF);
            end
            default: begin
                load_val = XLEN'(sel_word);
                if (!req_unsigned && sel_word[31]) load_val = load_val | ~XLEN'(32'hFFFF_FFFF);
            end
        endcase
    end

    always_comb begin
        case (req_size)
            2'd0:    wmask = LINE_WIDTH'(32'h0000_00FF);
            2'd1:    wmask = LINE_WIDTH'(32'h0000_FFFF);
            default: wmask = LINE_WIDTH'(32'hFFFF_FFFF);
        endcase
        wdata_line  = LINE_WIDTH'(req_wdata[31:0]) & wmask;
        merged_line = (hit_line & ~(wmask << {req_off, 3'b000}))
                    | (wdata_line << {req_off, 3'b000});
    end

    assign req_ready       = (state == IDLE) && req_valid && hit;
    assign rdata           = (req_ready && !req_write) ? load_val : '0;
    assign wb_done         = (state == WB) && mem_resp && arbiter_grant;
    assign fill_ok         = (state == FETCH) && mem_resp && arbiter_grant
                          && (mem_resp_addr[ADDR_WIDTH-1:OFF_W] == {lat_tag, lat_idx});
    assign unused_resp_off = ^mem_resp_addr[OFF_W-1:0];

    always_comb begin
        state_next    = state;
        mem_req       = 1'b0;
        mem_req_write = 1'b0;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        case (state)
            IDLE: begin
                if (req_valid && !hit) begin
                    state_next = (valid_arr[req_idx][victim] && dirty_arr[req_idx][victim]) ? WB : FETCH;
                end
            end
            WB: begin
                mem_req       = 1'b1;
                mem_req_write = 1'b1;
                mem_req_addr  = {tag_arr[lat_idx][lat_way], lat_idx, {OFF_W{1'b0}}};
                mem_req_data  = data_arr[lat_idx][lat_way];
                if (wb_done) state_next = FETCH;
            end
            FETCH: begin
                mem_req      = 1'b1;
                mem_req_addr = {lat_tag, lat_idx, {OFF_W{1'b0}}};
                if (fill_ok) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            lat_idx <= '0;
            lat_tag <= '0;
            lat_way <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                rr_ptr[s]    <= '0;
            end
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid && !hit) begin
                lat_idx <= req_idx;
                lat_tag <= req_tag;
                lat_way <= victim;
            end
            if (req_ready && req_write) dirty_arr[req_idx][hit_way] <= 1'b1;
            if (wb_done) dirty_arr[lat_idx][lat_way] <= 1'b0;
            if (fill_ok) begin
                valid_arr[lat_idx][lat_way] <= 1'b1;
                dirty_arr[lat_idx][lat_way] <= 1'b0;
                rr_ptr[lat_idx] <= (NUM_WAYS > 1) ? rr_ptr[lat_idx] + WAY_W'(1) : '0;
            end
        end
    end

    // Tag and data storage need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (req_ready && req_write) data_arr[req_idx][hit_way] <= merged_line;
        if (fill_ok) begin
            data_arr[lat_idx][lat_way] <= mem_resp_data;
            tag_arr[lat_idx][lat_way]  <= lat_tag;
        end
    end
endmodule

// File: tb/tb_cache_ctrl_sa.sv
// tb/tb_cache_ctrl_sa.sv - self-checking bench for cache_ctrl_sa (vector table, corner sequences, random vs flat memory model)
module tb_cache_ctrl_sa;
    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_write, req_unsigned, req_ready;
    logic [31:0]  req_addr, req_wdata, rdata;
    logic [1:0]   req_size;
    logic         arbiter_grant, mem_req, mem_req_write, mem_resp;
    logic [31:0]  mem_req_addr, mem_resp_addr;
    logic [127:0] mem_req_data, mem_resp_data;

    int errors = 0;
    int checks = 0;

    logic [7:0] bmem [0:1023];
    logic [7:0] fmem [0:1023];

    bit m_valid [4][2];
    bit m_dirty [4][2];
    int m_line  [4][2];
    int m_ptr   [4];

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_miss;
        logic        exp_wb;
        logic [31:0] exp_wb_addr;
    } vec_t;

    vec_t tbl [13];

    always #5 clk = ~clk;

    cache_ctrl_sa #(.NUM_SETS(4), .NUM_WAYS(2), .ADDR_WIDTH(32), .LINE_WIDTH(128), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata), .req_ready(req_ready), .rdata(rdata),
        .arbiter_grant(arbiter_grant), .mem_req(mem_req), .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_resp(mem_resp),
        .mem_resp_data(mem_resp_data), .mem_resp_addr(mem_resp_addr)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] bline(input logic [31:0] a);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[i*8 +: 8] = bmem[int'(a & 32'h3F0) + i];
        return l;
    endfunction

    function automatic logic [127:0] fline(input logic [31:0] a);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[i*8 +: 8] = fmem[int'(a & 32'h3F0) + i];
        return l;
    endfunction

    task automatic set_word(input int a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) bmem[a + i] = w[i*8 +: 8];
    endtask

    function automatic logic [31:0] align(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd0) return a;
        else if (sz == 2'd1) return a & ~32'h1;
        else return a & ~32'h3;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [31:0] r;
        int b;
        b = int'(align(a, sz) & 32'h3FF);
        if (sz == 2'd0) begin
            r = {24'h0, fmem[b]};
            if (!uns && r[7]) r = r | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            r = {16'h0, fmem[b+1], fmem[b]};
            if (!uns && r[15]) r = r | 32'hFFFF_0000;
        end else begin
            r = {fmem[b+3], fmem[b+2], fmem[b+1], fmem[b]};
        end
        return r;
    endfunction

    task automatic fmem_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int b, n;
        b = int'(align(a, sz) & 32'h3FF);
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) fmem[b + i] = wd[i*8 +: 8];
    endtask

    // Set-associative occupancy model: invalid way first, else per-set round-robin; fills advance the pointer.
    task automatic model_access(input bit wr, input logic [31:0] a, output bit miss, output bit wb,
                                output logic [31:0] wb_a);
        int s, ln, w, v;
        ln = int'(a) / 16;
        s  = ln % 4;
        w  = -1;
        for (int i = 0; i < 2; i++) if (m_valid[s][i] && m_line[s][i] == ln) w = i;
        miss = (w < 0);
        wb   = 1'b0;
        wb_a = '0;
        if (miss) begin
            v = -1;
            for (int i = 1; i >= 0; i--) if (!m_valid[s][i]) v = i;
            if (v < 0) v = m_ptr[s];
            wb   = m_valid[s][v] && m_dirty[s][v];
            wb_a = 32'(m_line[s][v] * 16);
            m_valid[s][v] = 1'b1;
            m_dirty[s][v] = 1'b0;
            m_line[s][v]  = ln;
            m_ptr[s]      = (m_ptr[s] + 1) % 2;
            w = v;
        end
        if (wr) m_dirty[s][w] = 1'b1;
    endtask

    // Drives one request and plays the memory side (random latency, random grant noise) until req_ready.
    task automatic do_access(input logic wr, input logic [31:0] a, input logic [1:0] sz, input logic uns,
                             input logic [31:0] wd, output logic [31:0] rd, output int cyc,
                             output int n_wb, output int n_fetch, output logic [31:0] wb_addr,
                             output logic [127:0] wb_data, output logic [31:0] fetch_addr, output logic done);
        int cnt, lat;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_size = sz; req_unsigned = uns; req_wdata = wd;
        cyc = 0; n_wb = 0; n_fetch = 0; done = 1'b0; cnt = 0; lat = $urandom_range(0, 3);
        wb_addr = '0; wb_data = '0; fetch_addr = '0; rd = '0;
        while (!done && cyc < 100) begin
            #1;
            if (req_ready) begin
                done = 1'b1;
                rd   = rdata;
            end
            mem_resp = 1'b0;
            arbiter_grant = 1'($urandom_range(0, 1));
            if (mem_req) begin
                if (cnt >= lat) begin
                    mem_resp = 1'b1;
                    arbiter_grant = 1'b1;
                    if (mem_req_write) begin
                        n_wb++;
                        wb_addr = mem_req_addr;
                        wb_data = mem_req_data;
                        for (int i = 0; i < 16; i++) bmem[int'(mem_req_addr & 32'h3F0) + i] = mem_req_data[i*8 +: 8];
                    end else begin
                        n_fetch++;
                        fetch_addr    = mem_req_addr;
                        mem_resp_addr = mem_req_addr;
                        mem_resp_data = bline(mem_req_addr);
                    end
                    cnt = 0;
                    lat = $urandom_range(0, 3);
                end else begin
                    cnt++;
                    if (!arbiter_grant) mem_resp = 1'($urandom_range(0, 1));
                end
            end
            @(posedge clk);
            @(negedge clk);
            if (!done) cyc++;
        end
        req_valid = 1'b0;
        mem_resp  = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  rd, wb_addr, fetch_addr, exp_rd, wb_a;
        logic [127:0] wb_data;
        logic         done;
        int           cyc, n_wb, n_fetch;
        bit           miss, wb;
        logic         wr, uns;
        logic [31:0]  a, wd;
        logic [1:0]   sz;

        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
        req_unsigned = 1'b0; req_wdata = '0; arbiter_grant = 1'b0; mem_resp = 1'b0;
        mem_resp_addr = '0; mem_resp_data = '0;
        for (int i = 0; i < 1024; i++) begin
            bmem[i] = 8'h00;
            fmem[i] = 8'h00;
        end
        set_word(32'h100, 32'hDEAD_BEEF);
        set_word(32'h140, 32'h1122_3344);
        set_word(32'h180, 32'h5566_7788);
        set_word(32'h1C4, 32'hCAFE_F00D);
        set_word(32'h210, 32'h8765_4321);

        tbl[0]  = '{1'b0, 32'h100, 2'd2, 1'b0, 32'h0,    32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h103, 2'd0, 1'b0, 32'h0,    32'hFFFF_FFDE, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 32'h103, 2'd0, 1'b1, 32'h0,    32'h0000_00DE, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 32'h102, 2'd1, 1'b0, 32'h1234, 32'h0,         1'b0, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 32'h100, 2'd2, 1'b0, 32'h0,    32'h1234_BEEF, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 32'h140, 2'd2, 1'b0, 32'h0,    32'h1122_3344, 1'b1, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 32'h180, 2'd2, 1'b0, 32'h0,    32'h5566_7788, 1'b1, 1'b1, 32'h100};
        tbl[7]  = '{1'b0, 32'h100, 2'd2, 1'b0, 32'h0,    32'h1234_BEEF, 1'b1, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 32'h141, 2'd1, 1'b0, 32'h0,    32'h0000_3344, 1'b1, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 32'h101, 2'd1, 1'b0, 32'h0,    32'hFFFF_BEEF, 1'b0, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 32'h141, 2'd0, 1'b0, 32'hAB,   32'h0,         1'b0, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 32'h1C4, 2'd2, 1'b0, 32'h0,    32'hCAFE_F00D, 1'b1, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 32'h100, 2'd2, 1'b0, 32'h0,    32'h1234_BEEF, 1'b1, 1'b1, 32'h140};

        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_req_write", mem_req_write, 0);
        check("rst_mem_req_addr", mem_req_addr, 0);
        check("rst_mem_req_data", mem_req_data, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            do_access(tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata,
                      rd, cyc, n_wb, n_fetch, wb_addr, wb_data, fetch_addr, done);
            check($sformatf("vec%0d_timeout", i), done, 1);
            check($sformatf("vec%0d_miss", i), cyc > 0, tbl[i].exp_miss);
            check($sformatf("vec%0d_wb_count", i), n_wb, tbl[i].exp_wb ? 1 : 0);
            if (tbl[i].exp_wb) check($sformatf("vec%0d_wb_addr", i), wb_addr, tbl[i].exp_wb_addr);
            if (!tbl[i].wr) check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
        end
        check("wb_merged_0x100", bline(32'h100) & 128'hFFFF_FFFF, 32'h1234_BEEF);
        check("wb_merged_0x140", bline(32'h140) & 128'hFFFF_FFFF, 32'h1122_AB44);

        // Fetch ignores responses without grant and responses for another line.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h210; req_size = 2'd2; req_unsigned = 1'b0;
        mem_resp = 1'b0; arbiter_grant = 1'b0;
        #1;
        check("seqa_miss_not_ready", req_ready, 0);
        @(posedge clk); @(negedge clk); #1;
        check("seqa_fetch_req", mem_req, 1);
        check("seqa_fetch_write", mem_req_write, 0);
        check("seqa_fetch_addr", mem_req_addr, 32'h210);
        mem_resp = 1'b1; arbiter_grant = 1'b0; mem_resp_addr = 32'h210; mem_resp_data = bline(32'h210);
        @(posedge clk); @(negedge clk); #1;
        check("seqa_nogrant_hold", mem_req, 1);
        check("seqa_nogrant_addr", mem_req_addr, 32'h210);
        check("seqa_nogrant_ready", req_ready, 0);
        arbiter_grant = 1'b1; mem_resp_addr = 32'h250; mem_resp_data = '1;
        @(posedge clk); @(negedge clk); #1;
        check("seqa_mismatch_hold", mem_req, 1);
        check("seqa_mismatch_ready", req_ready, 0);
        mem_resp_addr = 32'h21C; mem_resp_data = bline(32'h210);
        @(posedge clk); @(negedge clk);
        mem_resp = 1'b0; arbiter_grant = 1'b0;
        #1;
        check("seqa_replay_ready", req_ready, 1);
        check("seqa_replay_rdata", rdata, 32'h8765_4321);
        check("seqa_idle_mem_req", mem_req, 0);
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;

        // Reset in the middle of a writeback abandons it and invalidates the cache.
        do_access(1'b1, 32'h1C0, 2'd2, 1'b0, 32'h5A5A_5A5A, rd, cyc, n_wb, n_fetch, wb_addr, wb_data, fetch_addr, done);
        check("seqb_store_hit", cyc, 0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h140; req_size = 2'd2; mem_resp = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        check("seqb_wb_req", mem_req, 1);
        check("seqb_wb_write", mem_req_write, 1);
        check("seqb_wb_addr", mem_req_addr, 32'h1C0);
        check("seqb_wb_data", mem_req_data & 128'hFFFF_FFFF, 32'h5A5A_5A5A);
        #2;
        reset = 1'b0;
        #1;
        check("seqb_rst_mem_req", mem_req, 0);
        check("seqb_rst_mem_req_write", mem_req_write, 0);
        check("seqb_rst_mem_req_addr", mem_req_addr, 0);
        check("seqb_rst_req_ready", req_ready, 0);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_access(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, rd, cyc, n_wb, n_fetch, wb_addr, wb_data, fetch_addr, done);
        check("seqb_post_rst_miss", cyc > 0, 1);
        check("seqb_post_rst_no_wb", n_wb, 0);
        check("seqb_post_rst_rdata", rd, 32'h1234_BEEF);

        reset = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            bmem[i] = 8'($urandom);
            fmem[i] = bmem[i];
        end
        for (int s = 0; s < 4; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_line[s][w]  = 0;
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 300; n++) begin
            wr  = ($urandom_range(0, 2) == 0);
            a   = 32'($urandom_range(0, 255));
            sz  = 2'($urandom_range(0, 2));
            uns = 1'($urandom_range(0, 1));
            wd  = $urandom;
            exp_rd = exp_load(a, sz, uns);
            model_access(wr, a, miss, wb, wb_a);
            do_access(wr, a, sz, uns, wd, rd, cyc, n_wb, n_fetch, wb_addr, wb_data, fetch_addr, done);
            check("rnd_timeout", done, 1);
            check("rnd_miss", cyc > 0, miss);
            check("rnd_wb_count", n_wb, wb ? 1 : 0);
            if (miss) check("rnd_fetch_addr", fetch_addr, a & ~32'hF);
            if (wb) begin
                check("rnd_wb_addr", wb_addr, wb_a);
                check("rnd_wb_data", wb_data, fline(wb_a));
            end
            if (!wr) check("rnd_rdata", rd, exp_rd);
            else fmem_store(a, sz, wd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
